// File: rtl/kof_pkg.sv
// Shared types for the fighting-game match logic: round FSM states,
// round-result codes and a small constant helper.
package kof_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INTRO      = 3'd1,
        FIGHT      = 3'd2,
        KO         = 3'd3,
        MATCH_OVER = 3'd4
    } round_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic int max_frames(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/round_ctrl_frame_delay.sv
// Loadable frame-tick down-counter; done fires on the tick that finds the
// count at zero, so loading N-1 yields a delay of exactly N ticks.
module frame_delay #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && tick && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = en & tick & (cnt_reg == '0);

endmodule

// File: rtl/round_ctrl.sv
// Match/round sequencer: start key -> intro freeze -> fight -> KO freeze,
// judging each round from HP and timer and tracking round wins.
module round_ctrl
    import kof_pkg::*;
#(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int INTRO_FRAMES  = 120,
    parameter int KO_FRAMES     = 180,
    parameter int HP_W          = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_tick,
    input  logic            start_key,
    input  logic [5:0]      seconds,
    input  logic [HP_W-1:0] char1_hp,
    input  logic [HP_W-1:0] char2_hp,
    output logic            stop,
    output logic            round_rst,
    output logic [2:0]      state,
    output logic [2:0]      round_num,
    output logic [1:0]      p1_wins,
    output logic [1:0]      p2_wins,
    output logic [1:0]      round_winner,
    output logic            match_over
);

    localparam int CNT_W = $clog2(max_frames(INTRO_FRAMES, KO_FRAMES));
    localparam logic [CNT_W-1:0] INTRO_LOAD = CNT_W'(INTRO_FRAMES - 1);
    localparam logic [CNT_W-1:0] KO_LOAD    = CNT_W'(KO_FRAMES - 1);
    localparam logic [1:0]       WINS_MAX   = 2'(ROUNDS_TO_WIN);
    localparam logic [2:0]       ROUND_MAX  = 3'(MAX_ROUNDS);

    round_state_t     state_reg;
    logic             stop_reg, round_rst_reg, match_over_reg, start_key_q_reg;
    logic [2:0]       round_num_reg;
    logic [1:0]       round_winner_reg;
    logic [1:0]       wins_reg  [2];
    logic [1:0]       wins_next [2];

    logic             start_edge, new_match, round_decided, match_end, delay_done;
    logic             delay_load;
    logic [CNT_W-1:0] delay_load_val;
    logic [1:0]       verdict;

    assign start_edge    = start_key & ~start_key_q_reg;
    assign new_match     = start_edge && (state_reg == IDLE || state_reg == MATCH_OVER);
    assign round_decided = (state_reg == FIGHT) && (verdict != WIN_NONE);
    assign match_end     = (wins_reg[0] == WINS_MAX) || (wins_reg[1] == WINS_MAX) ||
                           (round_num_reg == ROUND_MAX);

    // KO by HP outranks timeout; a timeout compares remaining HP.
    always_comb begin
        verdict = WIN_NONE;
        if (char1_hp == '0 && char2_hp == '0) begin
            verdict = WIN_DRAW;
        end else if (char1_hp == '0) begin
            verdict = WIN_P2;
        end else if (char2_hp == '0) begin
            verdict = WIN_P1;
        end else if (seconds == 6'd0) begin
            if (char1_hp > char2_hp) begin
                verdict = WIN_P1;
            end else if (char1_hp < char2_hp) begin
                verdict = WIN_P2;
            end else begin
                verdict = WIN_DRAW;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_wins
        localparam logic [1:0] OWN_CODE = (gi == 0) ? WIN_P1 : WIN_P2;
        assign wins_next[gi] =
            new_match ? 2'd0 :
            (round_decided && verdict == OWN_CODE && wins_reg[gi] != WINS_MAX) ?
                wins_reg[gi] + 2'd1 : wins_reg[gi];
    end

    always_comb begin
        delay_load     = 1'b0;
        delay_load_val = INTRO_LOAD;
        if (new_match) begin
            delay_load = 1'b1;
        end else if (round_decided) begin
            delay_load     = 1'b1;
            delay_load_val = KO_LOAD;
        end else if (state_reg == KO && delay_done && !match_end) begin
            delay_load = 1'b1;
        end
    end

    frame_delay #(.CNT_W(CNT_W)) u_frame_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (delay_load),
        .load_val (delay_load_val),
        .en       (state_reg == INTRO || state_reg == KO),
        .tick     (frame_tick),
        .done     (delay_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            stop_reg         <= 1'b1;
            round_rst_reg    <= 1'b0;
            round_num_reg    <= 3'd0;
            round_winner_reg <= WIN_NONE;
            match_over_reg   <= 1'b0;
            start_key_q_reg  <= 1'b0;
            wins_reg[0]      <= 2'd0;
            wins_reg[1]      <= 2'd0;
        end else begin
            start_key_q_reg <= start_key;
            round_rst_reg   <= 1'b0;
            wins_reg[0]     <= wins_next[0];
            wins_reg[1]     <= wins_next[1];
            case (state_reg)
                IDLE, MATCH_OVER: begin
                    if (start_edge) begin
                        state_reg        <= INTRO;
                        round_num_reg    <= 3'd1;
                        round_winner_reg <= WIN_NONE;
                        round_rst_reg    <= 1'b1;
                        match_over_reg   <= 1'b0;
                        stop_reg         <= 1'b1;
                    end
                end
                INTRO: begin
                    if (delay_done) begin
                        state_reg <= FIGHT;
                        stop_reg  <= 1'b0;
                    end
                end
                FIGHT: begin
                    if (verdict != WIN_NONE) begin
                        state_reg        <= KO;
                        stop_reg         <= 1'b1;
                        round_winner_reg <= verdict;
                    end
                end
                KO: begin
                    if (delay_done) begin
                        if (match_end) begin
                            state_reg      <= MATCH_OVER;
                            match_over_reg <= 1'b1;
                        end else begin
                            state_reg     <= INTRO;
                            round_num_reg <= round_num_reg + 3'd1;
                            round_rst_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    stop_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign state        = state_reg;
    assign stop         = stop_reg;
    assign round_rst    = round_rst_reg;
    assign round_num    = round_num_reg;
    assign p1_wins      = wins_reg[0];
    assign p2_wins      = wins_reg[1];
    assign round_winner = round_winner_reg;
    assign match_over   = match_over_reg;

endmodule

// File: tb/tb_round_ctrl.sv
// Randomised bench for round_ctrl: a phase/frames-left model predicts every
// output each cycle, with directed scenarios and literal spot checks on top.
module tb_round_ctrl;

    localparam int R_WIN    = 2;
    localparam int MAX_RND  = 5;
    localparam int N_INTRO  = 120;
    localparam int N_KO     = 180;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_key = 1'b0;
    logic [5:0] seconds = 6'd30;
    logic [7:0] char1_hp = 8'd100;
    logic [7:0] char2_hp = 8'd100;
    logic       stop, round_rst, match_over;
    logic [2:0] state, round_num;
    logic [1:0] p1_wins, p2_wins, round_winner;

    always #5 clk = ~clk;

    round_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start_key    (start_key),
        .seconds      (seconds),
        .char1_hp     (char1_hp),
        .char2_hp     (char2_hp),
        .stop         (stop),
        .round_rst    (round_rst),
        .state        (state),
        .round_num    (round_num),
        .p1_wins      (p1_wins),
        .p2_wins      (p2_wins),
        .round_winner (round_winner),
        .match_over   (match_over)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // Model: phase 0 idle, 1 intro, 2 fight, 3 ko, 4 match over.
    int m_phase = 0, m_left = 0, m_round = 0, m_w1 = 0, m_w2 = 0, m_rw = 0;
    int m_key_q = 0, m_rst = 0, m_edge = 0, m_v = 0;

    function automatic int judge(input int h1, input int h2, input int sec);
        if (h1 == 0 && h2 == 0) return 3;
        if (h1 == 0) return 2;
        if (h2 == 0) return 1;
        if (sec == 0) return (h1 > h2) ? 1 : (h1 < h2) ? 2 : 3;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_phase = 0; m_left = 0; m_round = 0; m_w1 = 0; m_w2 = 0;
            m_rw = 0; m_key_q = 0; m_rst = 0;
            check_en = 1'b1;
        end else begin
            m_edge  = (start_key && m_key_q == 0) ? 1 : 0;
            m_key_q = start_key ? 1 : 0;
            m_rst   = 0;
            case (m_phase)
                0, 4: if (m_edge != 0) begin
                    m_w1 = 0; m_w2 = 0; m_rw = 0; m_round = 1; m_rst = 1;
                    m_phase = 1; m_left = N_INTRO;
                end
                1: if (frame_tick) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: begin
                    m_v = judge(int'(char1_hp), int'(char2_hp), int'(seconds));
                    if (m_v != 0) begin
                        m_rw = m_v;
                        if (m_v == 1 && m_w1 < R_WIN) m_w1++;
                        if (m_v == 2 && m_w2 < R_WIN) m_w2++;
                        m_phase = 3; m_left = N_KO;
                    end
                end
                3: if (frame_tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_w1 == R_WIN || m_w2 == R_WIN || m_round == MAX_RND) begin
                            m_phase = 4;
                        end else begin
                            m_round++; m_rst = 1; m_phase = 1; m_left = N_INTRO;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            chk("state", int'(state), m_phase);
            chk("stop", int'(stop), (m_phase == 2) ? 0 : 1);
            chk("round_rst", int'(round_rst), m_rst);
            chk("round_num", int'(round_num), m_round);
            chk("p1_wins", int'(p1_wins), m_w1);
            chk("p2_wins", int'(p2_wins), m_w2);
            chk("round_winner", int'(round_winner), m_rw);
            chk("match_over", int'(match_over), (m_phase == 4) ? 1 : 0);
        end
    end

    // One cycle of background stimulus that never decides a round.
    task automatic cyc();
        @(negedge clk);
        frame_tick = ($urandom_range(0, 3) != 0);
        char1_hp   = 8'($urandom_range(1, 255));
        char2_hp   = 8'($urandom_range(1, 255));
        seconds    = 6'($urandom_range(1, 59));
    endtask

    task automatic wait_phase(input int p, input int alt, input string name);
        int k = 0;
        while (m_phase != p && m_phase != alt && k < 3000) begin
            cyc();
            k++;
        end
        if (m_phase == alt) chk(name, int'(state), alt);
        else chk(name, int'(state), p);
    endtask

    task automatic start_match();
        @(negedge clk);
        start_key = 1'b1;
        cyc();
        start_key = 1'b0;
    endtask

    // kind: 0 P1 by KO, 1 P2 by KO, 2 double KO with tick, 3 random timeout, 4 timeout 40/40
    task automatic decide(input int kind);
        repeat ($urandom_range(0, 5)) cyc();
        @(negedge clk);
        frame_tick = ($urandom_range(0, 1) != 0);
        char1_hp   = 8'($urandom_range(1, 255));
        char2_hp   = 8'($urandom_range(1, 255));
        seconds    = 6'($urandom_range(1, 59));
        case (kind)
            0: char2_hp = 8'd0;
            1: char1_hp = 8'd0;
            2: begin char1_hp = 8'd0; char2_hp = 8'd0; frame_tick = 1'b1; end
            3: begin
                seconds = 6'd0;
                if ($urandom_range(0, 3) == 0) char2_hp = char1_hp;
            end
            default: begin seconds = 6'd0; char1_hp = 8'd40; char2_hp = 8'd40; end
        endcase
        cyc();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_stop"}, int'(stop), 1);
        chk({tag, "_rst"}, int'(round_rst), 0);
        chk({tag, "_round"}, int'(round_num), 0);
        chk({tag, "_wins"}, int'({p1_wins, p2_wins}), 0);
        chk({tag, "_winner"}, int'(round_winner), 0);
        chk({tag, "_over"}, int'(match_over), 0);
    endtask

    initial begin
        // Key held through reset counts as an edge right after reset.
        start_key = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        cyc();
        chk("start_state", int'(state), 1);
        chk("start_rst", int'(round_rst), 1);
        chk("start_round", int'(round_num), 1);
        cyc();
        chk("start_rst_once", int'(round_rst), 0);
        cyc();
        start_key = 1'b0;
        wait_phase(2, 2, "intro_to_fight");
        chk("fight_stop", int'(stop), 0);

        decide(0);
        chk("ko_state", int'(state), 3);
        chk("ko_p1_wins", int'(p1_wins), 1);
        chk("ko_winner", int'(round_winner), 1);
        chk("ko_stop", int'(stop), 1);
        wait_phase(1, 1, "ko_to_intro");
        chk("r2_round", int'(round_num), 2);
        chk("r2_rst", int'(round_rst), 1);

        wait_phase(2, 2, "r2_fight");
        decide(0);
        start_key = 1'b1;
        wait_phase(4, 4, "p1_match_over");
        chk("mo_flag", int'(match_over), 1);
        chk("mo_p1_wins", int'(p1_wins), 2);
        repeat (10) cyc();
        chk("mo_held_key", int'(state), 4);
        start_key = 1'b0;
        cyc();

        // Five draws run the match to the round limit.
        start_match();
        for (int r = 0; r < MAX_RND; r++) begin
            wait_phase(2, 2, "draw_fight");
            decide(4);
            chk("draw_winner", int'(round_winner), 3);
            chk("draw_wins", int'({p1_wins, p2_wins}), 0);
        end
        wait_phase(4, 4, "draw_match_over");
        chk("draw_last_round", int'(round_num), 5);

        // Double KO with a simultaneous frame tick.
        start_match();
        wait_phase(2, 2, "dko_fight");
        decide(2);
        chk("dko_state", int'(state), 3);
        chk("dko_winner", int'(round_winner), 3);
        wait_phase(1, 1, "dko_next_intro");
        repeat (20) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_reset_values("intro_rst");

        // Reset mid-fight in round 2 after a P2 round win.
        start_match();
        wait_phase(2, 2, "mid_fight1");
        decide(1);
        wait_phase(2, 2, "mid_fight2");
        chk("mid_round", int'(round_num), 2);
        chk("mid_p2", int'(p2_wins), 1);
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_reset_values("fight_rst");

        // Random matches against the model.
        for (int m = 0; m < 3; m++) begin
            start_match();
            for (int r = 0; r < MAX_RND && m_phase != 4; r++) begin
                wait_phase(2, 4, "rand_fight");
                if (m_phase == 2) decide($urandom_range(0, 4));
            end
            wait_phase(4, 4, "rand_over");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
